// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
// Shared types and helpers for the data-memory responder.
//   dmem_state_t : responder FSM states (IDLE, WAIT, RESP)
//   BE_*         : the byte-lane write-enable patterns the core may issue
//   be_legal()   : 1 when a lane pattern is one of the BE_* patterns
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;  // read
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_H0   = 4'b0011;
  localparam logic [3:0] BE_H1   = 4'b1100;
  localparam logic [3:0] BE_W    = 4'b1111;

  function automatic logic be_legal(logic [3:0] be);
    logic ok;
    case (be)
      BE_NONE, BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: ok = 1'b1;
      default:                                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// ---------------------------------------------------------------------------
// dmem_byte_ram
// Backing store built from four byte-wide arrays, one per lane.
//   clk   : clock
//   we    : per-lane write enable (lane i <- wdata[8i+7:8i])
//   waddr : write word index
//   wdata : write data
//   re    : read enable; rdata updates only on an enabled read
//   raddr : read word index
//   rdata : registered read data, held between reads
// Contents are not reset.
// ---------------------------------------------------------------------------
module dmem_byte_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (we[l]) mem[waddr] <= wdata[8*l +: 8];
      if (re)    rd_q       <= mem[raddr];
    end

    assign rdata[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Single-outstanding data-memory responder with fixed wait states.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (accepted only in IDLE)
//   req_addr              : byte address, word index = req_addr[31:2]
//   req_wdata             : lane-replicated write data
//   req_we                : byte-lane write enable, 0000 = read
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata             : stored word for good reads, else 0
//   rsp_err               : out-of-range index or illegal lane pattern
//   dbg_state             : current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; the initiator holds its payload stable until then, and the
// responder holds rsp_* stable while rsp_valid is 1 and rsp_ready is 0.
// ---------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_we,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output dmem_state_t dbg_state
);

  localparam int AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int WCNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  dmem_state_t       state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        we_q, we_d;
  logic              err_q, err_d;
  logic              rsp_read_q, rsp_read_d;
  logic              rsp_err_q, rsp_err_d;

  // Request decode straight from the inputs
  logic [AW-1:0] live_idx;
  logic          live_err;
  logic          unused_addr_lsbs;

  assign live_idx = req_addr[AW+1:2];
  assign live_err = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS)) || !be_legal(req_we);
  assign unused_addr_lsbs = ^req_addr[1:0];

  // Commit bundle: live request when there are no wait states, otherwise
  // the captured one.
  logic          commit;
  logic [AW-1:0] c_idx;
  logic [31:0]   c_wdata;
  logic [3:0]    c_we;
  logic          c_err;

  logic [3:0]    ram_we;
  logic          ram_re;
  logic [31:0]   ram_rdata;

  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_read_q ? ram_rdata : 32'h0;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    err_d      = err_q;
    rsp_read_d = rsp_read_q;
    rsp_err_d  = rsp_err_q;
    commit     = 1'b0;
    c_idx      = idx_q;
    c_wdata    = wdata_q;
    c_we       = we_q;
    c_err      = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          idx_d   = live_idx;
          wdata_d = req_wdata;
          we_d    = req_we;
          err_d   = live_err;
          if (WAIT_STATES == 0) begin
            commit  = 1'b1;
            c_idx   = live_idx;
            c_wdata = req_wdata;
            c_we    = req_we;
            c_err   = live_err;
            state_d = RESP;
          end else begin
            wcnt_d  = WCNT_W'(WAIT_STATES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end else begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_read_d = 1'b0;
          rsp_err_d  = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      rsp_read_d = (c_we == BE_NONE) && !c_err;
      rsp_err_d  = c_err;
    end
  end

  // Reset gates the RAM so an access aborted on the commit edge never lands.
  always_comb begin
    ram_we = 4'b0000;
    ram_re = 1'b0;
    if (commit && !reset && !c_err) begin
      ram_we = c_we;
      ram_re = (c_we == BE_NONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      we_q       <= '0;
      err_q      <= 1'b0;
      rsp_read_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      err_q      <= err_d;
      rsp_read_q <= rsp_read_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  dmem_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(c_idx),
    .wdata(c_wdata),
    .re   (ram_re),
    .raddr(c_idx),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Randomized and directed checks of dmem_responder against a word-level
// memory model. Instance dut uses WAIT_STATES=2, dut0 uses WAIT_STATES=0.
// ---------------------------------------------------------------------------
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DEPTH = 1024;
  localparam int WS    = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // dut (WAIT_STATES=2)
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_we;
  dmem_state_t dbg_state;

  // dut0 (WAIT_STATES=0)
  logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_we;
  dmem_state_t z_dbg_state;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
    .req_wdata(z_req_wdata), .req_we(z_req_we),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .dbg_state(z_dbg_state)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];              // {err, rdata}
  logic [31:0] model_mem [int];       // word index -> stored word

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic lanes_ok(logic [3:0] we);
    return we inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                      4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  // Word-level reference: decide the response and apply the write.
  task automatic model_issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
    int          idx;
    logic [31:0] w;
    idx = int'(a >> 2);
    if (idx >= DEPTH || !lanes_ok(we)) begin
      exp_q.push_back({1'b1, 32'h0});
    end else if (we == 4'b0000) begin
      w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      exp_q.push_back({1'b0, w});
    end else begin
      w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      for (int i = 0; i < 4; i++)
        if (we[i]) w[8*i +: 8] = wd[8*i +: 8];
      model_mem[idx] = w;
      exp_q.push_back({1'b0, 32'h0});
    end
  endtask

  // Full transaction on dut: accept, latency, hold for 'hold' cycles, handshake.
  task automatic xact(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                      input int hold, output logic [31:0] rd_out);
    logic [32:0] exp;
    int          lat;
    @(negedge clk);
    check_eq("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_addr = a; req_wdata = wd; req_we = we; rsp_ready = 1'b0;
    model_issue(a, wd, we);
    @(posedge clk); #1;
    // garbage on req_* while busy must be ignored
    req_valid = 1'($urandom_range(0, 1));
    req_addr  = $urandom; req_wdata = $urandom; req_we = 4'($urandom);
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      check_eq("req_ready_busy", req_ready, 0);
      @(negedge clk);
      lat++;
    end
    check_eq("rsp_valid_seen", rsp_valid, 1);
    check_eq("latency", lat + 1, WS + 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
    check_eq("rsp_rdata", rsp_rdata, exp[31:0]);
    check_eq("rsp_err", rsp_err, {31'h0, exp[32]});
    rd_out = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", rsp_valid, 1);
      check_eq("hold_ready", req_ready, 0);
      check_eq("hold_rdata", rsp_rdata, exp[31:0]);
      check_eq("hold_err", rsp_err, {31'h0, exp[32]});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("rsp_valid_drop", rsp_valid, 0);
    check_eq("req_ready_back", req_ready, 1);
  endtask

  initial begin
    logic [31:0] rd;
    int          acc[$];
    int          idx;
    logic [3:0]  we;

    reset = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = '0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_we = '0; z_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_state", dbg_state, IDLE);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", req_ready, 1);
    check_eq("post_rst_ready0", z_req_ready, 1);

    // Directed: full write then read of 0x10
    xact(32'h10, 32'hDEADBEEF, 4'b1111, 0, rd);
    xact(32'h10, 32'h0, 4'b0000, 0, rd);
    check_eq("rd_deadbeef", rd, 32'hDEADBEEF);
    // Byte write lane 2
    xact(32'h10, 32'h5A5A5A5A, 4'b0100, 0, rd);
    xact(32'h10, 32'h0, 4'b0000, 0, rd);
    check_eq("rd_byte_merge", rd, 32'hDE5ABEEF);
    // Out of range write, word 0 untouched
    xact(32'h0, 32'h01234567, 4'b1111, 0, rd);
    xact(32'h1000, 32'hFFFFFFFF, 4'b1111, 0, rd);
    xact(32'h0, 32'h0, 4'b0000, 0, rd);
    check_eq("rd_word0_kept", rd, 32'h01234567);
    // Illegal lanes with 5-cycle backpressure, then no write
    xact(32'h10, 32'h77777777, 4'b0101, 5, rd);
    xact(32'h10, 32'h0, 4'b0000, 5, rd);
    check_eq("rd_after_illegal", rd, 32'hDE5ABEEF);

    // Reset during WAIT aborts a write
    xact(32'hC, 32'h22222222, 4'b1111, 0, rd);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'hC; req_wdata = 32'h11111111; req_we = 4'b1111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_wait_state", dbg_state, WAIT);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_rsp_valid", rsp_valid, 0);
    check_eq("abort_req_ready", req_ready, 0);
    check_eq("abort_rdata", rsp_rdata, 0);
    check_eq("abort_err", rsp_err, 0);
    check_eq("abort_state", dbg_state, IDLE);
    reset = 1'b0;
    xact(32'hC, 32'h0, 4'b0000, 0, rd);
    check_eq("rd_word3_old", rd, 32'h22222222);

    // Reset during RESP keeps a committed write
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h14; req_wdata = 32'hCAFEF00D; req_we = 4'b1111;
    model_issue(32'h14, 32'hCAFEF00D, 4'b1111);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    check_eq("resp_before_rst", rsp_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("resp_dropped", rsp_valid, 0);
    reset = 1'b0;
    xact(32'h14, 32'h0, 4'b0000, 0, rd);
    check_eq("rd_word5_new", rd, 32'hCAFEF00D);

    // Fill words 0..15, then random traffic
    for (int i = 0; i < 16; i++) xact(i << 2, $urandom, 4'b1111, 0, rd);
    for (int n = 0; n < 60; n++) begin
      idx = ($urandom_range(0, 9) == 0) ? DEPTH + $urandom_range(0, 3000) : $urandom_range(0, 15);
      we  = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      xact((idx << 2) | $urandom_range(0, 3), $urandom, we, $urandom_range(0, 3), rd);
    end

    // WAIT_STATES=0 instance: write, then back-to-back reads
    @(negedge clk);
    z_req_valid = 1'b1; z_req_addr = 32'h0; z_req_wdata = 32'hA5A5C3C3; z_req_we = 4'b1111;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    @(negedge clk);
    check_eq("ws0_latency1", z_rsp_valid, 1);
    check_eq("ws0_wr_rdata", z_rsp_rdata, 0);
    check_eq("ws0_wr_err", z_rsp_err, 0);
    z_rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      if (z_req_ready) acc.push_back(k);
      if (z_rsp_valid) check_eq("ws0_rd", z_rsp_rdata, 32'hA5A5C3C3);
      @(negedge clk);
    end
    z_req_valid = 1'b0;
    check_eq("ws0_acc_count", acc.size(), 3);
    if (acc.size() >= 2) check_eq("ws0_spacing", acc[1] - acc[0], 2);
    else check_eq("ws0_spacing", 0, 2);
    @(negedge clk);
    @(negedge clk);
    check_eq("ws0_idle_end", z_req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core's load/store port. It accepts one word-addressed request at a time from the CPU's data-side initiator: address, lane-replicated write data and a 4-bit byte-lane write enable. After a fixed number of wait states it returns read data or a write acknowledge. It sits between the core's `daddr`/`dwdata`/`we` outputs and the backing data RAM, and adds a valid/ready handshake so that multi-cycle memories can be modelled.

## Interface

Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words in the backing store.
- `WAIT_STATES`, default 2: cycles inserted between request acceptance and response; legal range 0–15.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: responder can accept a request.
- `req_addr`  in  32: byte address; word index is `req_addr[31:2]`; `[1:0]` ignored.
- `req_wdata`  in  32: write data, already replicated across lanes by the core.
- `req_we`  in  4: byte-lane write enables; `4'b0000` means a read.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: core accepts the response.
- `rsp_rdata`  out  32: full stored word for reads; 0 for writes and errors.
- `rsp_err`  out  1: request was out of range or had an illegal lane pattern.

## Operation

- FSM has three states: IDLE, WAIT, RESP.
  - IDLE: `req_ready`=1. On `req_valid && req_ready`, capture addr, wdata and we.
    - If `WAIT_STATES`=0, go to RESP.
    - Otherwise load `wcnt`=`WAIT_STATES`-1 and go to WAIT.
  - WAIT: `req_ready`=0. While `wcnt`≠0, decrement `wcnt`. At 0, commit the access and go to RESP.
  - RESP: `rsp_valid`=1 and `req_ready`=0. Hold all response outputs stable until `rsp_ready`, then return to IDLE.
- Commit happens on the edge that enters RESP:
  - Reads latch `mem[idx]` into `rsp_rdata`.
  - Writes update only the lanes whose `req_we[i]`=1, taking byte i from `req_wdata[8i+7:8i]`. `rsp_rdata`=0.
- Error is decoded at capture time:
  - `idx >= DEPTH_WORDS`, or
  - `req_we` not in {0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111}.
- On error: no memory write, `rsp_rdata`=0, `rsp_err`=1, and the full latency still elapses.
- No back-to-back acceptance: a new request is accepted only in IDLE, so the minimum spacing between acceptances is `WAIT_STATES`+2 cycles.
- `req_*` inputs are ignored outside IDLE.

## Timing

- Reset values: state IDLE, `req_ready`=1 on the first cycle after reset (0 while `reset` is high), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `wcnt`=0.
- RAM contents are not reset.
- Latency from the accept edge to the first `rsp_valid` cycle is `WAIT_STATES`+1 cycles.
- `rsp_valid` deasserts on the cycle after the `rsp_valid && rsp_ready` edge, and `req_ready` reasserts in that same cycle.
- Reset mid-operation:
  - Reset during WAIT aborts the request; the write is not committed.
  - Reset during RESP drops the response; a write already committed stays in RAM.
- Reset has priority over every other event on the same edge, including a handshake.
- Read-after-write to the same word returns the new data, because commits are sequential.

## Structure

- `riscv_pkg` additions:
  - `dmem_state_t` enum {IDLE, WAIT, RESP}.
  - `BE_*` lane-pattern constants.
  - `function automatic logic be_legal(logic [3:0])`.
- `wcnt` width is `$clog2(WAIT_STATES+1)`, with a minimum of 1.
- Sub-module `dmem_byte_ram`: four byte-wide arrays of `DEPTH_WORDS` entries, one synchronous write port with per-lane enable, one synchronous read port. The responder holds only the FSM, capture registers and error decode.

## Test plan

- Reset, then `WAIT_STATES`=2, write 0xDEADBEEF to 0x10 with we=1111, then read 0x10 → `rsp_valid` 3 cycles after each accept; read returns 0xDEADBEEF with `rsp_err`=0.
- Byte write: word 0x10 holds 0xDEADBEEF; write wdata=0x5A5A5A5A with we=0100 → next read returns 0xDE5ABEEF.
- Out-of-range: `DEPTH_WORDS`=1024, write to addr 0x1000 → `rsp_err`=1, `rsp_rdata`=0, and a read of word 0 shows it unchanged.
- Illegal lanes: we=0101 → `rsp_err`=1 and no write. Backpressure: hold `rsp_ready`=0 for 5 cycles → `rsp_valid`, `rsp_rdata` and `rsp_err` stay stable and `req_ready` stays 0 for the whole hold.
- Reset mid-WAIT on a write of 0x11111111 to word 3 (previously 0x22222222) → outputs return to reset values, and a later read of word 3 returns 0x22222222.
- `WAIT_STATES`=0: read accepted → `rsp_valid` on the next cycle; with `req_valid` held high, a second acceptance occurs 2 cycles after the first.
